// File: rtl/fxp_pkg.sv
// Shared fixed-point definitions: default operand geometry and the
// extension-fill helper used when widening operands.
package fxp_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 16;
  localparam int DEFAULT_FRACTION_SIZE = 15;
  localparam int DEFAULT_SIGNED        = 1;
  localparam int DEFAULT_GUARD         = 1;

  // Bit used to fill the upper part of a widened operand: the operand's
  // sign bit for two's-complement arithmetic, zero for unsigned.
  function automatic logic ext_fill(input logic msb, input logic is_signed);
    return msb & is_signed;
  endfunction

endpackage

// File: rtl/fxp_relu_reg.sv
// Registered ReLU stage: one cycle of latency, the valid flag travels
// alongside the data, and reset clears both.
module fxp_relu_reg
  import fxp_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] relu_x,
  input  logic                  relu_in_valid,
  output logic [DATA_WIDTH-1:0] relu_out,
  output logic                  relu_out_valid
);

  logic [DATA_WIDTH-1:0] relu_out_d;
  logic [DATA_WIDTH-1:0] relu_out_q;
  logic                  relu_out_valid_d;
  logic                  relu_out_valid_q;

  // Next state: clamp negatives to zero, pass the valid flag through, reset wins.
  always_comb begin
    relu_out_d       = relu_x[DATA_WIDTH-1] ? '0 : relu_x;
    relu_out_valid_d = relu_in_valid;
    if (rst) begin
      relu_out_d       = '0;
      relu_out_valid_d = 1'b0;
    end
  end

  // Output registers; data is loaded every cycle and qualified by the valid flag.
  always_ff @(posedge clk) begin
    relu_out_q       <= relu_out_d;
    relu_out_valid_q <= relu_out_valid_d;
  end

  assign relu_out       = relu_out_q;
  assign relu_out_valid = relu_out_valid_q;

endmodule

// File: rtl/fxp_arith_relu.sv
// Fixed-point arithmetic slice: full-width combinational multiplier,
// guard-bit combinational adder, and a registered ReLU stage.
module fxp_arith_relu
  import fxp_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int FRACTION_SIZE = DEFAULT_FRACTION_SIZE,
  parameter int SIGNED        = DEFAULT_SIGNED,
  parameter int GUARD         = DEFAULT_GUARD
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         mul_a,
  input  logic [DATA_WIDTH-1:0]         mul_b,
  output logic [2*DATA_WIDTH-1:0]       mul_y,
  input  logic [2*DATA_WIDTH-1:0]       add_a,
  input  logic [2*DATA_WIDTH-1:0]       add_b,
  output logic [2*DATA_WIDTH+GUARD-1:0] add_y,
  input  logic [DATA_WIDTH-1:0]         relu_x,
  input  logic                          relu_in_valid,
  output logic [DATA_WIDTH-1:0]         relu_out,
  output logic                          relu_out_valid
);

  localparam int   PROD_W     = 2 * DATA_WIDTH;
  localparam int   ADD_W      = 2 * DATA_WIDTH + GUARD;
  localparam logic SIGNED_BIT = (SIGNED != 0);

  // The fraction field must fit inside the operand; the product then
  // carries 2*FRACTION_SIZE fraction bits and the adder keeps its binary point.
  if (FRACTION_SIZE > DATA_WIDTH || GUARD < 1) begin : g_param_check
    $error("fxp_arith_relu: FRACTION_SIZE must not exceed DATA_WIDTH and GUARD must be at least 1");
  end

  logic [PROD_W-1:0] mul_a_ext;
  logic [PROD_W-1:0] mul_b_ext;
  logic [ADD_W-1:0]  add_a_ext;
  logic [ADD_W-1:0]  add_b_ext;

  // Widening both multiplier operands to the product width makes the low
  // PROD_W bits of their product the exact signed or unsigned result.
  assign mul_a_ext = {{DATA_WIDTH{ext_fill(mul_a[DATA_WIDTH-1], SIGNED_BIT)}}, mul_a};
  assign mul_b_ext = {{DATA_WIDTH{ext_fill(mul_b[DATA_WIDTH-1], SIGNED_BIT)}}, mul_b};
  assign mul_y     = mul_a_ext * mul_b_ext;

  // Guard bits absorb the carry so the sum is exact without saturation.
  assign add_a_ext = {{GUARD{ext_fill(add_a[PROD_W-1], SIGNED_BIT)}}, add_a};
  assign add_b_ext = {{GUARD{ext_fill(add_b[PROD_W-1], SIGNED_BIT)}}, add_b};
  assign add_y     = add_a_ext + add_b_ext;

  fxp_relu_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_relu (
    .clk           (clk),
    .rst           (rst),
    .relu_x        (relu_x),
    .relu_in_valid (relu_in_valid),
    .relu_out      (relu_out),
    .relu_out_valid(relu_out_valid)
  );

endmodule

// File: tb/tb_fxp_arith_relu.sv
// Self-checking bench for fxp_arith_relu: a signed and an unsigned instance
// share stimulus and are compared every cycle against an arithmetic model.
module tb_fxp_arith_relu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mul_a = '0;
  logic [15:0] mul_b = '0;
  logic [31:0] add_a = '0;
  logic [31:0] add_b = '0;
  logic [15:0] relu_x = '0;
  logic        relu_in_valid = 1'b0;

  logic [31:0] s_mul_y;
  logic [32:0] s_add_y;
  logic [15:0] s_relu_out;
  logic        s_relu_valid;
  logic [31:0] u_mul_y;
  logic [32:0] u_add_y;
  logic [15:0] u_relu_out;
  logic        u_relu_valid;

  int checks = 0;
  int errors = 0;

  logic        model_live = 1'b0;
  logic        last_rst   = 1'b1;
  logic        last_valid = 1'b0;
  logic [15:0] last_x     = '0;

  always #5 clk = ~clk;

  fxp_arith_relu #(.DATA_WIDTH(16), .FRACTION_SIZE(15), .SIGNED(1), .GUARD(1)) dut_s (
    .clk(clk), .rst(rst),
    .mul_a(mul_a), .mul_b(mul_b), .mul_y(s_mul_y),
    .add_a(add_a), .add_b(add_b), .add_y(s_add_y),
    .relu_x(relu_x), .relu_in_valid(relu_in_valid),
    .relu_out(s_relu_out), .relu_out_valid(s_relu_valid)
  );

  fxp_arith_relu #(.DATA_WIDTH(16), .FRACTION_SIZE(15), .SIGNED(0), .GUARD(1)) dut_u (
    .clk(clk), .rst(rst),
    .mul_a(mul_a), .mul_b(mul_b), .mul_y(u_mul_y),
    .add_a(add_a), .add_b(add_b), .add_y(u_add_y),
    .relu_x(relu_x), .relu_in_valid(relu_in_valid),
    .relu_out(u_relu_out), .relu_out_valid(u_relu_valid)
  );

  // Exact product as an integer, reduced to the 32-bit output field.
  function automatic logic [63:0] model_mul(input logic [15:0] a, input logic [15:0] b, input bit sgn);
    longint pa, pb;
    pa = sgn ? longint'($signed(a)) : longint'(a);
    pb = sgn ? longint'($signed(b)) : longint'(b);
    return 64'(pa * pb) & 64'hFFFF_FFFF;
  endfunction

  // Exact sum as an integer, reduced to the 33-bit output field.
  function automatic logic [63:0] model_add(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint pa, pb;
    pa = sgn ? longint'($signed(a)) : longint'(a);
    pb = sgn ? longint'($signed(b)) : longint'(b);
    return 64'(pa + pb) & 64'h1_FFFF_FFFF;
  endfunction

  // ReLU on the two's-complement value of x.
  function automatic logic [15:0] model_relu(input logic [15:0] x);
    int v;
    v = int'($signed(x));
    return (v < 0) ? 16'd0 : x;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [15:0] x);
    @(posedge clk);
    #1;
    rst           = r;
    relu_in_valid = v;
    relu_x        = x;
  endtask

  task automatic applyArith(input logic [15:0] a, input logic [15:0] b,
                            input logic [31:0] c, input logic [31:0] d);
    mul_a = a;
    mul_b = b;
    add_a = c;
    add_b = d;
  endtask

  // Remember what each rising edge saw so the output one cycle later can be predicted.
  always @(posedge clk) begin
    model_live = 1'b1;
    last_rst   = rst;
    last_valid = relu_in_valid;
    last_x     = relu_x;
  end

  // Every falling edge: arithmetic against current inputs, ReLU against the previous edge.
  always @(negedge clk) begin
    if (model_live) begin
      checkOutput("mul_signed",   64'(s_mul_y), model_mul(mul_a, mul_b, 1'b1));
      checkOutput("mul_unsigned", 64'(u_mul_y), model_mul(mul_a, mul_b, 1'b0));
      checkOutput("add_signed",   64'(s_add_y), model_add(add_a, add_b, 1'b1));
      checkOutput("add_unsigned", 64'(u_add_y), model_add(add_a, add_b, 1'b0));
      checkOutput("relu_out_s",   64'(s_relu_out),   64'(last_rst ? 16'd0 : model_relu(last_x)));
      checkOutput("relu_valid_s", 64'(s_relu_valid), 64'(!last_rst && last_valid));
      checkOutput("relu_out_u",   64'(u_relu_out),   64'(last_rst ? 16'd0 : model_relu(last_x)));
      checkOutput("relu_valid_u", 64'(u_relu_valid), 64'(!last_rst && last_valid));
    end
  end

  initial begin
    logic [15:0] stream_in  [4] = '{16'h0101, 16'h7FFF, 16'h8000, 16'h4321};
    logic [15:0] stream_exp [4] = '{16'h0101, 16'h7FFF, 16'h0000, 16'h4321};
    logic [15:0] ra, rb;
    logic [31:0] rc, rd;
    logic [15:0] rx;

    $display("[TB] start");

    // Hand-computed arithmetic points.
    applyArith(16'h4000, 16'h4000, 32'h7FFF_FFFF, 32'h0000_0001);
    #1;
    checkOutput("lit_mul_half_half", 64'(s_mul_y), 64'h1000_0000);
    checkOutput("lit_add_pos_carry", 64'(s_add_y), 64'h0_8000_0000);
    applyArith(16'h8000, 16'h8000, 32'h8000_0000, 32'h8000_0000);
    #1;
    checkOutput("lit_mul_neg_neg",   64'(s_mul_y), 64'h4000_0000);
    checkOutput("lit_add_neg_neg",   64'(s_add_y), 64'h1_0000_0000);
    applyArith(16'h8000, 16'h4000, 32'hFFFF_FFFF, 32'h0000_0001);
    #1;
    checkOutput("lit_mul_neg_pos",   64'(s_mul_y), 64'hE000_0000);
    checkOutput("lit_add_m1_p1",     64'(s_add_y), 64'h0);
    checkOutput("lit_uadd_wrap",     64'(u_add_y), 64'h1_0000_0000);
    applyArith(16'hFFFF, 16'hFFFF, 32'h0, 32'h0);
    #1;
    checkOutput("lit_umul_max",      64'(u_mul_y), 64'hFFFE_0001);
    checkOutput("lit_smul_m1_m1",    64'(s_mul_y), 64'h0000_0001);

    // Reset state and directed ReLU points.
    applyStimulus(1'b1, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b1, 16'h1234);
    checkOutput("lit_reset_out",   64'(s_relu_out),   64'h0);
    checkOutput("lit_reset_valid", 64'(s_relu_valid), 64'h0);
    applyStimulus(1'b0, 1'b1, 16'h8001);
    checkOutput("lit_relu_1234",   64'(s_relu_out),   64'h1234);
    checkOutput("lit_relu_1234_v", 64'(s_relu_valid), 64'h1);
    applyStimulus(1'b0, 1'b1, 16'h0000);
    checkOutput("lit_relu_8001",   64'(s_relu_out),   64'h0);
    applyStimulus(1'b0, 1'b1, 16'h8000);
    checkOutput("lit_relu_zero",   64'(s_relu_out),   64'h0);
    applyStimulus(1'b0, 1'b0, 16'h7FFF);
    checkOutput("lit_relu_minneg", 64'(s_relu_out),   64'h0);
    applyStimulus(1'b0, 1'b0, 16'h0);
    checkOutput("lit_relu_novalid_data",  64'(s_relu_out),   64'h7FFF);
    checkOutput("lit_relu_novalid_flag",  64'(s_relu_valid), 64'h0);

    // Four back-to-back valid inputs then one idle cycle.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, (i < 4), (i < 4) ? stream_in[i] : 16'h0);
      if (i > 0) begin
        checkOutput("lit_stream_data",  64'(s_relu_out),   64'(stream_exp[i-1]));
        checkOutput("lit_stream_valid", 64'(s_relu_valid), 64'h1);
      end
    end
    applyStimulus(1'b0, 1'b0, 16'h0);
    checkOutput("lit_stream_idle", 64'(s_relu_valid), 64'h0);

    // Reset in the middle of a valid stream.
    applyStimulus(1'b0, 1'b1, 16'h1111);
    applyStimulus(1'b1, 1'b1, 16'h2222);
    checkOutput("lit_pre_reset_data", 64'(s_relu_out), 64'h1111);
    applyStimulus(1'b0, 1'b1, 16'h3333);
    checkOutput("lit_midrst_out",   64'(s_relu_out),   64'h0);
    checkOutput("lit_midrst_valid", 64'(s_relu_valid), 64'h0);
    applyStimulus(1'b0, 1'b0, 16'h0);
    checkOutput("lit_resume_data",  64'(s_relu_out),   64'h3333);
    checkOutput("lit_resume_valid", 64'(s_relu_valid), 64'h1);

    // Randomized traffic with a bias toward boundary values.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0:       rx = 16'h0000;
        1:       rx = 16'h8000;
        2:       rx = 16'h7FFF;
        3:       rx = 16'hFFFF;
        default: rx = 16'($urandom);
      endcase
      ra = ($urandom_range(0, 4) == 0) ? 16'h8000 : 16'($urandom);
      rb = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
      rc = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
      rd = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom;
      applyStimulus(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0), rx);
      applyArith(ra, rb, rc, rd);
    end

    applyStimulus(1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 16'h0);
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
